// File: rtl/mem_bank_responder_pkg.sv
// Shared types and constants for the per-bank memory responder: bus codes,
// widths, the queued request record and the service FSM encoding.
package mem_bank_responder_pkg;
    localparam int PADDR_W = 15;
    localparam int LINE_W  = 128;
    localparam int ID_W    = 4;
    localparam int SIZE_W  = 16;
    localparam int IDX_W   = 9;
    localparam int LINES   = 1 << IDX_W;

    localparam logic [1:0]        DEST_PFX = 2'b10;
    localparam logic [SIZE_W-1:0] SIZE_WR  = 16'h8000;
    localparam logic [SIZE_W-1:0] SIZE_RD  = 16'h1000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic [PADDR_W-1:0] paddr;
        logic [ID_W-1:0]    ret;
        logic               rw;
        logic [LINE_W-1:0]  data;
    } req_t;

    // A request is ours only if routing, bank bits and size/rw pairing all agree.
    function automatic logic req_legal(input logic [1:0] bank, input logic [ID_W-1:0] dest,
                                       input logic [1:0] pa_bank, input logic [SIZE_W-1:0] size,
                                       input logic rw);
        return (dest == {DEST_PFX, bank}) && (pa_bank == bank) &&
               (rw ? (size == SIZE_WR) : (size == SIZE_RD));
    endfunction
endpackage

// File: rtl/mem_bank_responder_if.sv
// Request/response channel between the bus deserializer and one bank responder.
interface mem_bank_responder_if;
    import mem_bank_responder_pkg::*;

    logic               req_valid;
    logic               req_ready;
    logic [PADDR_W-1:0] req_pAddress;
    logic [ID_W-1:0]    req_return;
    logic [SIZE_W-1:0]  req_size;
    logic               req_rw;
    logic [ID_W-1:0]    req_dest;
    logic [LINE_W-1:0]  req_data;

    logic               resp_valid;
    logic               resp_ready;
    logic [PADDR_W-1:0] resp_pAddress;
    logic [LINE_W-1:0]  resp_data;
    logic [ID_W-1:0]    resp_dest;
    logic [ID_W-1:0]    resp_return;

    logic               busy;
    logic               err_dest;

    modport slave (
        input  req_valid, req_pAddress, req_return, req_size, req_rw, req_dest, req_data,
        input  resp_ready,
        output req_ready, resp_valid, resp_pAddress, resp_data, resp_dest, resp_return,
        output busy, err_dest
    );

    modport master (
        output req_valid, req_pAddress, req_return, req_size, req_rw, req_dest, req_data,
        output resp_ready,
        input  req_ready, resp_valid, resp_pAddress, resp_data, resp_dest, resp_return,
        input  busy, err_dest
    );
endinterface

// File: rtl/mem_bank_responder_req_fifo.sv
// In-order request queue; full/empty come from a registered occupancy count.
module mem_bank_responder_req_fifo
    import mem_bank_responder_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  req_t wdata_i,
    input  logic pop_i,
    output req_t rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [PW:0]   count_q, count_d;
    req_t          mem_q [DEPTH];

    assign count_d = count_q + (PW+1)'(push_i) - (PW+1)'(pop_i);

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == (PW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
endmodule

// File: rtl/mem_bank_responder.sv
// One interleaved memory bank: filters and queues line requests, serves them
// one at a time against a 512-line array and returns read fills.
module mem_bank_responder
    import mem_bank_responder_pkg::*;
#(
    parameter logic [1:0] BANK_ID    = 2'b00,
    parameter int         FIFO_DEPTH = 4,
    parameter int         MEM_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_bank_responder_if.slave  bus
);
    localparam int CW = $clog2(MEM_LAT + 1);

    state_e             state_q, state_d;
    req_t               head, work_q;
    logic               full, empty, accept, legal, push;
    logic               pop, commit, latch, resp_valid;
    logic [CW-1:0]      cnt_q;
    logic [LINE_W-1:0]  array_q [LINES];
    logic [PADDR_W-1:0] resp_paddr_q;
    logic [LINE_W-1:0]  resp_data_q;
    logic [ID_W-1:0]    resp_dest_q, resp_return_q;
    logic               err_q;

    assign accept = bus.req_valid && !full;
    assign legal  = req_legal(BANK_ID, bus.req_dest, bus.req_pAddress[5:4], bus.req_size, bus.req_rw);
    assign push   = accept && legal;

    mem_bank_responder_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i ('{paddr: bus.req_pAddress, ret: bus.req_return, rw: bus.req_rw, data: bus.req_data}),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (!empty) state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == '0) state_d = work_q.rw ? ST_IDLE : ST_RESP;
            ST_RESP:   if (bus.resp_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        pop        = 1'b0;
        commit     = 1'b0;
        latch      = 1'b0;
        resp_valid = 1'b0;
        unique case (state_q)
            ST_IDLE:   pop = !empty;
            ST_ACCESS: begin
                commit = (cnt_q == '0) &&  work_q.rw;
                latch  = (cnt_q == '0) && !work_q.rw;
            end
            ST_RESP:   resp_valid = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            work_q        <= '0;
            cnt_q         <= '0;
            resp_paddr_q  <= '0;
            resp_data_q   <= '0;
            resp_dest_q   <= '0;
            resp_return_q <= '0;
            err_q         <= 1'b0;
        end else begin
            if (pop) begin
                work_q <= head;
                cnt_q  <= CW'(MEM_LAT - 1);
            end else if (state_q == ST_ACCESS && cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
            // Response fields freeze here and stay put for the whole RESP stall.
            if (latch) begin
                resp_data_q   <= array_q[work_q.paddr[PADDR_W-1:6]];
                resp_paddr_q  <= work_q.paddr;
                resp_dest_q   <= work_q.ret;
                resp_return_q <= {DEST_PFX, BANK_ID};
            end
            err_q <= accept && !legal;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) array_q[work_q.paddr[PADDR_W-1:6]] <= work_q.data;
    end

    assign bus.req_ready     = !full;
    assign bus.resp_valid    = resp_valid;
    assign bus.resp_pAddress = resp_paddr_q;
    assign bus.resp_data     = resp_data_q;
    assign bus.resp_dest     = resp_dest_q;
    assign bus.resp_return   = resp_return_q;
    assign bus.busy          = (state_q != ST_IDLE) || !empty;
    assign bus.err_dest      = err_q;
endmodule

// File: tb/tb_mem_bank_responder.sv
// Bench for mem_bank_responder (BANK_ID=0, FIFO_DEPTH=4, MEM_LAT=2): directed
// scenarios plus a randomized write/read stream checked against a line model.
module tb_mem_bank_responder;
  import mem_bank_responder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_bank_responder_if bus();

  mem_bank_responder #(.BANK_ID(2'b00), .FIFO_DEPTH(4), .MEM_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [3:0]   OWN = 4'b1000;
  localparam logic [127:0] A5  = {16{8'hA5}};

  typedef struct {
    logic [14:0]  pa;
    logic [3:0]   ret;
    logic [127:0] data;
  } exp_t;

  int           n_cmp = 0;
  int           n_bad = 0;
  logic [127:0] ref_line [int];
  exp_t         exp_q [$];

  function automatic logic [14:0] mk_pa(input int idx, input logic [3:0] lo);
    return {idx[8:0], 2'b00, lo};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Present one request starting at a negedge; returns at the negedge after it is taken.
  task automatic send(input logic [14:0] pa, input logic [3:0] ret, input logic [15:0] size,
                      input logic rw, input logic [3:0] dest, input logic [127:0] data);
    int t = 0;
    while (!bus.req_ready && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: req_ready=%0b after %0d cycles, required 1", bus.req_ready, t);
    end
    bus.req_pAddress = pa;  bus.req_return = ret;  bus.req_size = size;
    bus.req_rw = rw;        bus.req_dest = dest;   bus.req_data = data;
    bus.req_valid = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic wr(input logic [14:0] pa, input logic [3:0] ret, input logic [127:0] data);
    send(pa, ret, SIZE_WR, 1'b1, OWN, data);
    ref_line[int'(pa[14:6])] = data;
  endtask

  task automatic rd(input logic [14:0] pa, input logic [3:0] ret);
    exp_t e;
    send(pa, ret, SIZE_RD, 1'b0, OWN, 128'h0);
    e.pa = pa; e.ret = ret; e.data = ref_line[int'(pa[14:6])];
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (bus.busy && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: busy=%0b after %0d cycles, required 0", bus.busy, t);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.busy, bus.err_dest} !== 4'b1000) begin
      n_bad++;
      $display("FAIL reset_ctl: {rdy,vld,busy,err}=%b, required 1000",
               {bus.req_ready, bus.resp_valid, bus.busy, bus.err_dest});
    end
    n_cmp++;
    if ({bus.resp_pAddress, bus.resp_dest, bus.resp_return} !== 23'h0 || bus.resp_data !== 128'h0) begin
      n_bad++;
      $display("FAIL reset_resp: pa=%h dest=%h ret=%h data=%h, required all zero",
               bus.resp_pAddress, bus.resp_dest, bus.resp_return, bus.resp_data);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.busy} !== 2'b10) begin
      n_bad++;
      $display("FAIL reset_release: {rdy,busy}=%b, required 10", {bus.req_ready, bus.busy});
    end
  endtask

  task automatic test_write_read();
    int lat = 0;
    wait_idle();
    bus.resp_ready = 1'b0;
    wr(15'h0040, 4'h1, A5);
    n_cmp++;
    if (bus.err_dest !== 1'b0) begin
      n_bad++; $display("FAIL wr_legal_err: err_dest=%b, required 0", bus.err_dest);
    end
    wait_idle();
    send(15'h0040, 4'h3, SIZE_RD, 1'b0, OWN, 128'h0);
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++;
    if (lat != 3) begin
      n_bad++; $display("FAIL rd_latency: resp_valid after %0d cycles, required 3", lat);
    end
    n_cmp++;
    if (bus.resp_data !== A5 || bus.resp_pAddress !== 15'h0040 ||
        bus.resp_dest !== 4'h3 || bus.resp_return !== 4'b1000) begin
      n_bad++;
      $display("FAIL rd_fields: pa=%h dest=%h ret=%h data=%h, required 0040 3 8 %h",
               bus.resp_pAddress, bus.resp_dest, bus.resp_return, bus.resp_data, A5);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== A5) begin
      n_bad++;
      $display("FAIL rd_hold: vld=%b data=%h, required 1 %h", bus.resp_valid, bus.resp_data, A5);
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_handshake: vld=%b busy=%b, required 0 0", bus.resp_valid, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] d0 = rnd128();
    logic [127:0] d1 = ~d0;
    int bad = 0;
    int lat = 0;
    wait_idle();
    wr(mk_pa(3, 4'h5), 4'h2, d0);
    wait_idle();
    send(mk_pa(3, 4'h0), 4'h2, SIZE_WR, 1'b1, OWN, d1);
    send(mk_pa(3, 4'h0), 4'h6, SIZE_RD, 1'b0, OWN, 128'h0);
    n_cmp++;
    if (bus.busy !== 1'b1) begin
      n_bad++; $display("FAIL mid_busy: busy=%b before reset, required 1", bus.busy);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.busy, bus.err_dest} !== 4'b1000 ||
        bus.resp_data !== 128'h0 || {bus.resp_pAddress, bus.resp_dest, bus.resp_return} !== 23'h0) begin
      n_bad++;
      $display("FAIL mid_reset: {rdy,vld,busy,err}=%b pa=%h data=%h, required 1000 0 0",
               {bus.req_ready, bus.resp_valid, bus.busy, bus.err_dest}, bus.resp_pAddress, bus.resp_data);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad != 0) begin
      n_bad++; $display("FAIL mid_discard: %0d cycles with activity after reset, required 0", bad);
    end
    send(mk_pa(3, 4'h0), 4'h7, SIZE_RD, 1'b0, OWN, 128'h0);
    while (!bus.resp_valid && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++;
    if (bus.resp_valid !== 1'b1 || bus.resp_data !== d0) begin
      n_bad++;
      $display("FAIL mid_lost_write: vld=%b data=%h, required 1 %h", bus.resp_valid, bus.resp_data, d0);
    end
    @(negedge clk);
  endtask

  task automatic test_drop();
    logic [3:0]  dests [5] = '{4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0100};
    logic [14:0] pas   [5] = '{15'h0040, 15'h0050, 15'h0040, 15'h0040, 15'h0040};
    logic [15:0] sizes [5] = '{SIZE_RD, SIZE_RD, SIZE_WR, SIZE_RD, SIZE_RD};
    logic        rws   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int act = 0;
    wait_idle();
    for (int i = 0; i < 5; i++) begin
      send(pas[i], 4'h2, sizes[i], rws[i], dests[i], rnd128());
      n_cmp++;
      if (bus.err_dest !== 1'b1 || bus.busy !== 1'b0) begin
        n_bad++;
        $display("FAIL drop_%0d: err=%b busy=%b, required 1 0", i, bus.err_dest, bus.busy);
      end
      @(negedge clk);
      n_cmp++;
      if (bus.err_dest !== 1'b0) begin
        n_bad++; $display("FAIL drop_pulse_%0d: err=%b one cycle later, required 0", i, bus.err_dest);
      end
    end
    repeat (5) begin
      @(negedge clk);
      if (bus.resp_valid !== 1'b0) act++;
    end
    n_cmp++;
    if (act != 0) begin
      n_bad++; $display("FAIL drop_noresp: %0d response cycles, required 0", act);
    end
  endtask

  task automatic test_backpressure();
    int got = 0;
    int cyc = 0;
    wait_idle();
    for (int i = 0; i < 5; i++) wr(mk_pa(10 + i, 4'h0), 4'h0, rnd128());
    wait_idle();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 5; i++) rd(mk_pa(10 + i, 4'(i)), 4'(i + 4));
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bus.req_ready, bus.resp_valid, bus.busy} !== 3'b011 || bus.resp_pAddress !== exp_q[0].pa) begin
      n_bad++;
      $display("FAIL bp_full: {rdy,vld,busy}=%b pa=%h, required 011 %h",
               {bus.req_ready, bus.resp_valid, bus.busy}, bus.resp_pAddress, exp_q[0].pa);
    end
    bus.resp_ready = 1'b1;
    while (got < 5 && cyc < 200) begin
      if (bus.resp_valid) begin
        exp_t e = exp_q.pop_front();
        n_cmp++;
        if (bus.resp_pAddress !== e.pa || bus.resp_dest !== e.ret ||
            bus.resp_return !== OWN || bus.resp_data !== e.data) begin
          n_bad++;
          $display("FAIL bp_resp_%0d: pa=%h dest=%h data=%h, required %h %h %h",
                   got, bus.resp_pAddress, bus.resp_dest, bus.resp_data, e.pa, e.ret, e.data);
        end
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    if (got < 5) begin
      n_cmp++; n_bad++;
      $display("FAIL bp_timeout: %0d responses, required 5", got);
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 24;
    logic rw_op [N];
    int   nrd = 0;
    int   got = 0;
    wait_idle();
    exp_q.delete();
    for (int i = 0; i < N; i++) begin
      rw_op[i] = (i < 2) ? 1'b1 : 1'($urandom_range(0, 1));
      if (!rw_op[i]) nrd++;
    end
    fork
      begin
        for (int i = 0; i < N; i++) begin
          logic [14:0] pa = (i % 2 == 0) ? 15'h0040 : 15'h0080;
          if (rw_op[i]) wr(pa, 4'($urandom_range(0, 15)), rnd128());
          else          rd(pa, 4'($urandom_range(0, 15)));
        end
      end
      begin
        int cyc = 0;
        while (got < nrd && cyc < 2000) begin
          bus.resp_ready = 1'($urandom_range(0, 1));
          if (bus.resp_valid && bus.resp_ready && exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            n_cmp++;
            if (bus.resp_pAddress !== e.pa || bus.resp_dest !== e.ret || bus.resp_data !== e.data) begin
              n_bad++;
              $display("FAIL b2b_resp_%0d: pa=%h dest=%h data=%h, required %h %h %h",
                       got, bus.resp_pAddress, bus.resp_dest, bus.resp_data, e.pa, e.ret, e.data);
            end
            got++;
          end
          @(negedge clk);
          cyc++;
        end
      end
    join
    bus.resp_ready = 1'b1;
    if (got < nrd) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_timeout: %0d responses, required %0d", got, nrd);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;  bus.req_pAddress = '0;  bus.req_return = '0;
    bus.req_size = '0;     bus.req_rw = 1'b0;      bus.req_dest = '0;
    bus.req_data = '0;     bus.resp_ready = 1'b1;
    test_reset();
    test_write_read();
    test_reset_mid();
    test_drop();
    test_backpressure();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end
endmodule
